// File: rtl/tia_audio_pkg.sv
// rtl/tia_audio_pkg.sv - shared constants and types for the TIA audio channel
package tia_audio_pkg;

  localparam int AUDC_W = 4;
  localparam int AUDF_W = 5;
  localparam int AUDV_W = 4;

  localparam logic [1:0] ADDR_AUDC = 2'd0;
  localparam logic [1:0] ADDR_AUDF = 2'd1;
  localparam logic [1:0] ADDR_AUDV = 2'd2;
  localparam logic [1:0] ADDR_CLR  = 2'd3;

  typedef enum logic {
    HS_EMPTY = 1'b0,
    HS_FULL  = 1'b1
  } hs_state_t;

endpackage

// File: rtl/aud_freq_divider.sv
// rtl/aud_freq_divider.sv - audio tick prescaler and AUDF frequency counter
module aud_freq_divider
  import tia_audio_pkg::*;
#(
  parameter int TICK_DIV = 114
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AUDF_W-1:0] audf,
  output logic              poly_step
);

  localparam logic [7:0] PRE_LAST = 8'(TICK_DIV - 1);

  logic [7:0]        pre_cnt;
  logic              tick;
  logic [AUDF_W-1:0] fcnt;

  // Prescaler wraps at TICK_DIV-1; tick is registered so the first one lands TICK_DIV cycles after reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= 8'd0;
      tick    <= 1'b0;
    end else begin
      tick    <= (pre_cnt == PRE_LAST);
      pre_cnt <= (pre_cnt == PRE_LAST) ? 8'd0 : pre_cnt + 8'd1;
    end
  end

  // Frequency counter; >= compare so lowering AUDF below fcnt wraps on the next tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt      <= '0;
      poly_step <= 1'b0;
    end else begin
      poly_step <= 1'b0;
      if (tick) begin
        if (fcnt >= audf) begin
          fcnt      <= '0;
          poly_step <= 1'b1;
        end else begin
          fcnt <= fcnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/tia_audio_channel.sv
// rtl/tia_audio_channel.sv - TIA audio channel: registers, sample generation, output handshake
module tia_audio_channel
  import tia_audio_pkg::*;
#(
  parameter int AUD_TICK_DIV = 114
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [4:0]        wr_data,
  input  logic              poly_bit,
  output logic              poly_step,
  output logic [AUDC_W-1:0] audc_out,
  output logic [AUDV_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun
);

  logic [AUDC_W-1:0] audc;
  logic [AUDF_W-1:0] audf;
  logic [AUDV_W-1:0] audv;
  logic              out_bit;
  logic              new_sample;
  logic [AUDV_W-1:0] sample_next;
  logic              clr_overrun;
  hs_state_t         state;

  assign audc_out    = audc;
  assign clr_overrun = wr_en && (wr_addr == ADDR_CLR);

  aud_freq_divider #(
    .TICK_DIV(AUD_TICK_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .audf     (audf),
    .poly_step(poly_step)
  );

  // Register file; the reserved address only clears overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      audc <= '0;
      audf <= '0;
      audv <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_AUDC: audc <= wr_data[AUDC_W-1:0];
        ADDR_AUDF: audf <= wr_data[AUDF_W-1:0];
        ADDR_AUDV: audv <= wr_data[AUDV_W-1:0];
        default:   ;
      endcase
    end
  end

  // Capture the pre-shift poly bit on each step; the sample is built the cycle after
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_bit    <= 1'b0;
      new_sample <= 1'b0;
    end else begin
      new_sample <= poly_step;
      if (poly_step) out_bit <= poly_bit;
    end
  end

  // AUDC=0 is a DC level; otherwise the captured bit gates the volume
  always_comb begin
    sample_next = '0;
    if (audc == '0 || out_bit) sample_next = audv;
  end

  // Single-slot output buffer; overwrite without acceptance raises sticky overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= HS_EMPTY;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (clr_overrun) overrun <= 1'b0;
      case (state)
        HS_EMPTY: begin
          if (new_sample) begin
            sample_data  <= sample_next;
            sample_valid <= 1'b1;
            state        <= HS_FULL;
          end
        end
        HS_FULL: begin
          if (new_sample) begin
            sample_data <= sample_next;
            if (!sample_ready) overrun <= 1'b1;
          end else if (sample_ready) begin
            sample_valid <= 1'b0;
            state        <= HS_EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tia_audio_channel.sv
// tb/tb_tia_audio_channel.sv - scoreboard bench for tia_audio_channel
module tb_tia_audio_channel;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [4:0] wr_data = 5'd0;
  logic       poly_bit = 1'b0;
  logic       poly_step;
  logic [3:0] audc_out;
  logic [3:0] sample_data;
  logic       sample_valid;
  logic       sample_ready = 1'b0;
  logic       overrun;

  int checks = 0;
  int passes = 0;

  // reference model state
  bit   armed = 0;
  int   exp_q[$];
  int   ov_m = 0, ps_m = 0, step_pend = 0, pbit = 0;
  int   fc = 0, cyc_idx = 0;
  int   audc_s = 0, audf_s = 0, audv_s = 0;

  tia_audio_channel #(.AUD_TICK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .poly_bit(poly_bit), .poly_step(poly_step), .audc_out(audc_out),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Monitor and reference model: compare visible outputs, then advance the model by one cycle
  always @(negedge clk) begin
    int  e, ps_next, set_ov, clr_ov;
    if (armed) begin
      chk("poly_step", poly_step, ps_m);
      chk("sample_valid", sample_valid, (exp_q.size() != 0) ? 1 : 0);
      if (exp_q.size() != 0) chk("sample_data", sample_data, exp_q[0]);
      chk("overrun", overrun, ov_m);
      chk("audc_out", audc_out, audc_s);
    end
    if (!rst_n) begin
      armed = 1;
      exp_q.delete();
      ov_m = 0; ps_m = 0; step_pend = 0; pbit = 0; fc = 0; cyc_idx = 0;
      audc_s = 0; audf_s = 0; audv_s = 0;
    end else if (armed) begin
      set_ov = 0;
      if (step_pend != 0) begin
        e = (audc_s == 0 || pbit != 0) ? audv_s : 0;
        if (exp_q.size() == 0) exp_q.push_back(e);
        else begin
          if (!sample_ready) set_ov = 1;
          void'(exp_q.pop_front());
          exp_q.push_back(e);
        end
      end else if (exp_q.size() != 0 && sample_ready) begin
        void'(exp_q.pop_front());
      end
      clr_ov = (wr_en && wr_addr == 2'd3) ? 1 : 0;
      ov_m = ((ov_m != 0 && clr_ov == 0) || set_ov != 0) ? 1 : 0;
      ps_next = 0;
      if (cyc_idx > 0 && cyc_idx % DIV == 0) begin
        if (fc >= audf_s) begin ps_next = 1; fc = 0; end
        else fc++;
      end
      step_pend = ps_m;
      if (ps_m != 0) pbit = poly_bit;
      ps_m = ps_next;
      if (wr_en) begin
        case (wr_addr)
          2'd0: audc_s = wr_data[3:0];
          2'd1: audf_s = wr_data;
          2'd2: audv_s = wr_data[3:0];
          default: ;
        endcase
      end
      cyc_idx++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  // cycles until the next cycle where poly_step is high (bounded)
  task automatic step_gap(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!poly_step && n < 200);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!sample_valid && n < 200) begin cyc(); n++; end
    chk("wait_valid_timeout", (n < 200) ? 1 : 0, 1);
  endtask

  initial begin
    int n;
    repeat (3) cyc();
    rst_n = 1'b1;

    // tone at full volume, alternating poly bit per step
    sample_ready = 1'b1;
    wr(2'd0, 5'd4); wr(2'd2, 5'd15); wr(2'd1, 5'd0);
    step_gap(n);
    step_gap(n);
    chk("period_audf0", n, DIV);
    for (int i = 0; i < 40; i++) begin
      poly_bit = ((i / DIV) % 2 == 0);
      cyc();
    end

    // AUDF=3 period, then lower AUDF to 1 while fcnt=3
    wr(2'd1, 5'd3);
    step_gap(n);
    step_gap(n);
    chk("period_audf3", n, 4 * DIV);
    repeat (3 * DIV) cyc();
    wr(2'd1, 5'd1);
    step_gap(n);
    chk("audf_lowered_latency", n, 3);
    step_gap(n);
    chk("period_audf1", n, 2 * DIV);

    // DC level
    wr(2'd0, 5'd0); wr(2'd2, 5'd9); wr(2'd1, 5'd0);
    poly_bit = 1'b0;
    repeat (30) cyc();

    // overrun: no acceptance across two steps, then clear via reserved address
    wr(2'd0, 5'd4); wr(2'd2, 5'd15);
    poly_bit = 1'b1;
    sample_ready = 1'b0;
    repeat (12) cyc();
    chk("overrun_set", overrun, 1);
    sample_ready = 1'b1;
    repeat (3) cyc();
    wr(2'd3, 5'd0);
    chk("overrun_cleared", overrun, 0);

    // new sample arrives with ready in the same cycle while FULL
    sample_ready = 1'b0;
    wait_valid();
    repeat (3) cyc();
    sample_ready = 1'b1;
    cyc();
    chk("full_new_ready_valid", sample_valid, 1);
    chk("full_new_ready_overrun", overrun, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sample_ready = $urandom_range(0, 1);
      poly_bit = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) begin
        logic [1:0] a;
        a = 2'($urandom_range(0, 3));
        wr(a, (a == 2'd1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)));
      end else begin
        cyc();
      end
    end

    // reset mid-handshake
    sample_ready = 1'b0;
    wait_valid();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("reset_drops_valid", sample_valid, 0);
    step_gap(n);
    chk("first_step_after_reset", n, DIV + 1);
    sample_ready = 1'b1;
    repeat (20) cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
